binary_arcade_round_gen: RTL
============================

Name: binary_arcade_round_gen

Overview:
Upstream stage of the binary arcade score counter. It generates the per-round challenge number with a free-running LFSR and holds it stable for one round. It times the player's response, compares the submitted binary pattern against the challenge, and emits one-cycle hit/miss pulses. The hit pulse is the increment qualifier the downstream score counter consumes; random_number drives the display.

Parameters:
WIDTH, 4, challenge/user_input width in bits (must be <= 8).
TIMEOUT_CYCLES, 100, cycles allowed per round before an automatic miss (>= 2).
ROUNDS, 10, rounds per game (>= 1).
SEED, 8'hA5, LFSR reset value (must be nonzero).

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 forces reset state immediately
start  in  1  level; sampled only in IDLE/DONE, begins a game
submit  in  1  one-cycle strobe; player commits user_input
user_input  in  WIDTH  player's binary answer
random_number  out  WIDTH  current challenge, stable throughout a round
round_active  out  1  high while a response is being accepted (WAIT)
hit  out  1  one-cycle pulse, correct answer
miss  out  1  one-cycle pulse, wrong answer or timeout
timeout  out  1  one-cycle pulse coincident with miss when caused by timer expiry
round_num  out  $clog2(ROUNDS+1)  rounds completed in current game
game_over  out  1  high in DONE

Behaviour:
- Reset (reset=0, async): state=IDLE; lfsr=SEED; random_number=0; timer=0; round_num=0; all pulses, round_active and game_over = 0.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Every cycle after reset release: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. It advances in every state and never reaches 0. From SEED A5 the sequence is A5, 4A, 95, ...
- IDLE: outputs quiet. start=1 -> LOAD; round_num<=0.
- LOAD (1 cycle): random_number <= lfsr[WIDTH-1:0] (current value); timer <= TIMEOUT_CYCLES-1; -> WAIT.
- WAIT: round_active=1.
  - submit=1 -> RESULT; registers hit=(user_input==random_number), miss=!hit.
  - else timer==0 -> RESULT; registers miss=1 and timeout=1.
  - else timer decrements.
  - submit in the same cycle as timer==0: submit wins, no timeout.
- RESULT (1 cycle): hit/miss/timeout are high in this cycle only. round_num increments. If the new value == ROUNDS -> DONE, else -> LOAD.
- DONE: game_over=1; round_num and random_number held. start=1 -> LOAD, round_num<=0, game_over drops next cycle.
- Latency: submit accepted in WAIT cycle N -> hit/miss high in cycle N+1 -> next challenge valid in cycle N+3 (LOAD at N+2).
- Ignored inputs: submit outside WAIT; start outside IDLE/DONE.
- Reset mid-round: immediate return to reset values. No pulse is emitted and round_num clears.
- hit and miss are never high together. At most one pulse pair per round.

Decomposition:
- Shared package binary_arcade_pkg holds:
  - the state encoding constants IDLE/LOAD/WAIT/RESULT/DONE;
  - the LFSR tap mask 8'hB8;
  - the default SEED;
  - WIDTH default 4, also used by the downstream counter.
- Sub-module binary_arcade_lfsr (8-bit, seed parameter, async active-low reset, free-running) is natural and reusable. The FSM, timer and comparator stay in the top module.

Test Plan:
- Reset, release, no start -> random_number=0, round_active=0; internal LFSR steps A5, 4A, 95 on successive cycles.
- start=1 one cycle -> LOAD then WAIT; random_number equals LFSR low nibble at LOAD; round_active=1 one cycle after LOAD; value stable until RESULT.
- In WAIT, submit with user_input==random_number -> hit=1 for exactly one cycle, miss=0, round_num 0->1, new LOAD two cycles after submit.
- In WAIT, submit with user_input==~random_number -> miss=1, hit=0, timeout=0.
- TIMEOUT_CYCLES=4, no submit -> miss=1 and timeout=1 in the cycle after the 4th WAIT cycle. Also: submit on the last WAIT cycle -> hit/miss from compare, timeout=0.
- ROUNDS=3, three correct submits -> round_num=3, game_over=1, hit pulses=3. Then start -> round_num=0. Separately: reset=0 mid-WAIT -> all outputs zero immediately, no pulse.

Source files
------------

// File: rtl/binary_arcade_pkg.sv
// binary_arcade_pkg: shared encodings and constants for the binary arcade blocks
package binary_arcade_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, WAIT, RESULT, DONE} state_t;
   localparam int         DEF_WIDTH  = 4;
   localparam logic [7:0] DEF_SEED   = 8'hA5;
   localparam logic [7:0] LFSR_TAPS  = 8'hB8;
   // x^8+x^6+x^5+x^4+1: feedback is the parity of the tapped bits
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction
endpackage

// File: rtl/binary_arcade_lfsr.sv
// binary_arcade_lfsr: free-running 8-bit Fibonacci LFSR exposing its low WIDTH bits
module binary_arcade_lfsr
   import binary_arcade_pkg::*;
#(
   parameter int         WIDTH = DEF_WIDTH,
   parameter logic [7:0] SEED  = DEF_SEED
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] value
);
   logic [7:0] state;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= SEED;
      else state <= lfsr_next(state);
   assign value = state[WIDTH-1:0];
endmodule

// File: rtl/binary_arcade_round_gen.sv
// binary_arcade_round_gen: per-round challenge generator, response timer and hit/miss judge
module binary_arcade_round_gen
   import binary_arcade_pkg::*;
#(
   parameter int         WIDTH          = DEF_WIDTH,
   parameter int         TIMEOUT_CYCLES = 100,
   parameter int         ROUNDS         = 10,
   parameter logic [7:0] SEED           = DEF_SEED
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          submit,
   input  logic [WIDTH-1:0]              user_input,
   output logic [WIDTH-1:0]              random_number,
   output logic                          round_active,
   output logic                          hit,
   output logic                          miss,
   output logic                          timeout,
   output logic [$clog2(ROUNDS+1)-1:0]   round_num,
   output logic                          game_over
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int RW = $clog2(ROUNDS+1);
   state_t            state_q, state_d;
   logic [TW-1:0]     timer;
   logic [WIDTH-1:0]  lfsr_low;
   logic              last_round, expired, idle_start;

   binary_arcade_lfsr #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .value (lfsr_low)
   );

   assign last_round = round_num == RW'(ROUNDS - 1);
   assign expired    = timer == '0;
   assign idle_start = (state_q == IDLE || state_q == DONE) && start;

   always_ff @(posedge clk or negedge reset)
      if (!reset) state_q <= IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: state_d = start ? LOAD : state_q;
         LOAD:       state_d = WAIT;
         WAIT:       state_d = (submit || expired) ? RESULT : WAIT;
         RESULT:     state_d = last_round ? DONE : LOAD;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      round_active = state_q == WAIT;
      game_over    = state_q == DONE;
   end

   // submit takes priority over expiry when both land in the same WAIT cycle
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         random_number <= '0;
         timer         <= '0;
         round_num     <= '0;
         hit           <= 1'b0;
         miss          <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         hit     <= 1'b0;
         miss    <= 1'b0;
         timeout <= 1'b0;
         if (state_q == LOAD) begin
            random_number <= lfsr_low;
            timer         <= TW'(TIMEOUT_CYCLES - 1);
         end
         if (state_q == WAIT) begin
            if (submit) begin
               hit  <= user_input == random_number;
               miss <= user_input != random_number;
            end else if (expired) begin
               miss    <= 1'b1;
               timeout <= 1'b1;
            end else timer <= timer - 1'b1;
         end
         if (idle_start) round_num <= '0;
         if (state_q == RESULT) round_num <= round_num + 1'b1;
      end
endmodule
